// File: rtl/nla_stream_pkg.sv
// rtl/nla_stream_pkg.sv - shared FSM states, FP32 field constants and NaN detect for the NLA stream path
package nla_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_state_e;

    localparam int FP32_EXP_MSB = 30;
    localparam int FP32_EXP_LSB = 23;
    localparam int FP32_MAN_MSB = 22;
    localparam int FP32_MAN_LSB = 0;
    localparam logic [7:0] FP32_EXP_ALL_ONES = 8'hFF;

    // Infinities (all-ones exponent, zero mantissa) are deliberately not NaN.
    function automatic logic fp32_is_nan(input logic [31:0] word);
        return (word[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_ALL_ONES) &&
               (word[FP32_MAN_MSB:FP32_MAN_LSB] != '0);
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - register-based skid FIFO absorbing the upstream read latency
module stream_skid_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [CW-1:0]         count,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The reader's credit rule must keep this buffer from ever overflowing.
    assert property (@(posedge clk_i) disable iff (!rstn_i) !(push && !pop && count == CW'(DEPTH)));
    assert property (@(posedge clk_i) disable iff (!rstn_i) !(pop && empty));

endmodule

// File: rtl/fp_stream_reader.sv
// rtl/fp_stream_reader.sv - credit-controlled FIFO drain to a framed FP32 stream (option: FP_READER_NAN_FILTER_EN)
module fp_stream_reader
    import nla_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int SKID_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  fifo_empty_i,
    input  logic                  fifo_wr_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_rd_en_o,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_first_o,
    output logic                  m_last_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  err_nan_o
);

    localparam int CW = $clog2(SKID_DEPTH) + 1;

    fsm_state_e            state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, issued_q, accepted_q;
    logic [RD_LATENCY-1:0] inflight_q;
    logic [CW-1:0]         inflight_cnt, skid_count;
    logic [CW:0]           credit_sum;
    logic                  rd_en, push, pop, skid_empty, last_accept, done_q;
    logic [DATA_WIDTH-1:0] push_data, head_data;

    assign push        = inflight_q[RD_LATENCY-1];
    assign pop         = ~skid_empty & m_ready_i;
    assign last_accept = pop && (accepted_q == len_q - LEN_WIDTH'(1));

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CW'(inflight_q[i]);
        end
    end

    // Credits count every word not yet handed downstream, so a stalled sink cannot overflow the skid.
    assign credit_sum = {1'b0, inflight_cnt} + {1'b0, skid_count};

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                rd_en = ~fifo_empty_i & ~fifo_wr_i & (credit_sum < (CW+1)'(SKID_DEPTH))
                      & (issued_q != len_q);
                if (rd_en && (issued_q + LEN_WIDTH'(1) == len_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if (last_accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= (inflight_q << 1) | RD_LATENCY'(rd_en);
            done_q     <= (state_q == DRAIN) && last_accept;
            if (state_q == IDLE && start_i) begin
                len_q      <= (len_i == '0) ? LEN_WIDTH'(1) : len_i;
                issued_q   <= '0;
                accepted_q <= '0;
            end else begin
                if (rd_en) issued_q   <= issued_q + LEN_WIDTH'(1);
                if (pop)   accepted_q <= accepted_q + LEN_WIDTH'(1);
            end
        end
    end

`ifdef FP_READER_NAN_FILTER_EN
    logic push_nan, err_nan_q;
    assign push_nan  = push & fp32_is_nan(fifo_data_i[31:0]);
    assign push_data = push_nan ? '0 : fifo_data_i;
    assign err_nan_o = err_nan_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) err_nan_q <= 1'b0;
        else         err_nan_q <= err_nan_q | push_nan;
    end
`else
    assign push_data = fifo_data_i;
    assign err_nan_o = 1'b0;
`endif

    stream_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head_data  (head_data),
        .count      (skid_count),
        .empty      (skid_empty)
    );

    assign fifo_rd_en_o = rd_en;
    assign m_valid_o    = ~skid_empty;
    assign m_data_o     = head_data;
    assign m_first_o    = m_valid_o && (accepted_q == '0);
    assign m_last_o     = m_valid_o && (accepted_q == len_q - LEN_WIDTH'(1));
    assign done_o       = done_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_fp_stream_reader.sv
// tb/tb_fp_stream_reader.sv - randomized scoreboard bench for fp_stream_reader
module tb_fp_stream_reader;

    localparam int DW  = 32;
    localparam int RDL = 2;
    localparam int SD  = 4;
    localparam int LW  = 16;

    logic          clk = 1'b0;
    logic          rstn_i = 1'b0;
    logic          fifo_empty_i = 1'b1;
    logic          fifo_wr_i = 1'b0;
    logic [DW-1:0] fifo_data_i = '0;
    logic          fifo_rd_en_o;
    logic          start_i = 1'b0;
    logic [LW-1:0] len_i = '0;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [DW-1:0] m_data_o;
    logic          m_first_o, m_last_o, done_o, busy_o, err_nan_o;

    always #5 clk = ~clk;

    fp_stream_reader #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (RDL),
        .SKID_DEPTH (SD),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_wr_i    (fifo_wr_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .start_i      (start_i),
        .len_i        (len_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .m_first_o    (m_first_o),
        .m_last_o     (m_last_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .err_nan_o    (err_nan_o)
    );

    typedef struct {
        logic [31:0] data;
        logic        first;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] hist[RDL];
    int          checks = 0;
    int          failures = 0;
    bit          exp_nan = 0;
    bit          force_empty = 0;
    int          ready_mode = 0, wr_mode = 0;
    int          cyc = 0, tb_issued, tb_accepted, max_out;
    int          first_rd, first_valid, last_acc;
    bit          done_seen, busy_at_done;

    function automatic bit ref_is_nan(input logic [31:0] w);
        return (((w >> 23) & 32'hFF) == 32'hFF) && ((w % (32'd1 << 23)) != 0);
    endfunction

    function automatic logic [31:0] ref_out(input logic [31:0] w);
`ifdef FP_READER_NAN_FILTER_EN
        return ref_is_nan(w) ? 32'h0 : w;
`else
        return w;
`endif
    endfunction

    function automatic bit exp_err();
`ifdef FP_READER_NAN_FILTER_EN
        return exp_nan;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat, checks hold stability and done timing.
    initial begin
        beat_t       b;
        logic [31:0] held = '0;
        bit          hold = 0;
        bit          exp_done = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn_i) begin
                hold = 0;
                exp_done = 0;
                continue;
            end
            if (done_o || exp_done) chk("done_pulse", done_o, exp_done);
            exp_done = 0;
            if (hold) begin
                chk("hold_valid", m_valid_o, 1);
                chk("hold_data", m_data_o, held);
            end
            hold = 0;
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", m_valid_o, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", m_data_o, b.data);
                    chk("beat_first", m_first_o, b.first);
                    chk("beat_last", m_last_o, b.last);
                    if (b.last) exp_done = 1;
                end
            end else if (m_valid_o) begin
                hold = 1;
                held = m_data_o;
            end
        end
    end

    task automatic tick(input bit st, input logic [LW-1:0] ln);
        @(negedge clk);
        start_i = st;
        len_i   = ln;
        case (ready_mode)
            0:       m_ready_i = 1'b1;
            1:       m_ready_i = (cyc % 2) == 0;
            2:       m_ready_i = 1'($urandom_range(0, 1));
            default: m_ready_i = 1'b0;
        endcase
        case (wr_mode)
            0:       fifo_wr_i = 1'b0;
            1:       fifo_wr_i = (cyc % 2) == 1;
            default: fifo_wr_i = ($urandom_range(0, 3) == 0);
        endcase
        fifo_empty_i = force_empty || (fifo_q.size() == 0);
        fifo_data_i  = hist[RDL-1];
        #1;
        if (fifo_rd_en_o) begin
            chk("rd_en_vs_wr", fifo_wr_i, 0);
            chk("rd_en_vs_empty", fifo_empty_i, 0);
            tb_issued++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid_o && first_valid < 0) first_valid = cyc;
        if (m_valid_o && m_ready_i) begin
            tb_accepted++;
            last_acc = cyc;
        end
        if (tb_issued - tb_accepted > max_out) max_out = tb_issued - tb_accepted;
        if (done_o && !done_seen) begin
            done_seen    = 1;
            busy_at_done = busy_o;
        end
        for (int i = RDL - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = (fifo_rd_en_o && fifo_q.size() > 0) ? fifo_q.pop_front() : $urandom();
        cyc++;
    endtask

    task automatic load_frame(input int len, input int nan_idx, input bit dir_vals, output int extra);
        int          L;
        logic [31:0] w;
        L = (len == 0) ? 1 : len;
        extra = $urandom_range(0, 3);
        fifo_q.delete();
        for (int i = 0; i < L; i++) begin
            w = dir_vals ? $shortrealtobits(shortreal'(i + 1)) : $urandom();
            if (i == nan_idx)     w = 32'h7FC0_0000;
            if (i == nan_idx + 1) w = 32'h7F80_0000;
            fifo_q.push_back(w);
            exp_q.push_back('{ref_out(w), i == 0, i == L - 1});
            if (ref_is_nan(w)) exp_nan = 1;
        end
        for (int i = 0; i < extra; i++) fifo_q.push_back($urandom());
        tb_issued = 0; tb_accepted = 0; max_out = 0;
        first_rd = -1; first_valid = -1; last_acc = -1;
        done_seen = 0; busy_at_done = 1;
    endtask

    task automatic run_frame(input int len, input int rmode, input int wmode,
                             input int gap_at, input int gap_len, input int nan_idx,
                             input bit dir_vals, input bit start_again, input bit timing);
        int L, extra, n;
        L = (len == 0) ? 1 : len;
        load_frame(len, nan_idx, dir_vals, extra);
        ready_mode = rmode;
        wr_mode    = wmode;
        tick(1, LW'(len));
        n = 0;
        while (!done_seen && n < 2000) begin
            force_empty = (n >= gap_at) && (n < gap_at + gap_len);
            tick(start_again && n == 3, LW'(5));
            if (n == 0) chk("busy_after_start", busy_o, 1);
            n++;
        end
        force_empty = 0;
        if (!done_seen) chk("frame_timeout", done_o, 1);
        tick(0, '0);
        chk("busy_at_done", busy_at_done, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("issued_count", tb_issued, L);
        chk("fifo_leftover", fifo_q.size(), extra);
        chk("outstanding_le_depth", max_out <= SD, 1);
        chk("err_nan", err_nan_o, exp_err());
        if (timing) begin
            chk("first_valid_latency", first_valid - first_rd, RDL + 1);
            chk("throughput", last_acc - first_valid + 1, L);
        end
    endtask

    initial begin
        int extra;
        for (int i = 0; i < RDL; i++) hist[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", m_valid_o, 0);
        chk("rst_rd_en", fifo_rd_en_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_data", m_data_o, 0);
        chk("rst_err", err_nan_o, 0);
        @(negedge clk);
        rstn_i = 1'b1;

        run_frame(8, 0, 0, 0, 0, -10, 1, 0, 1);
        run_frame(16, 1, 0, 0, 0, -10, 0, 0, 0);
        run_frame(12, 2, 1, 0, 0, -10, 0, 1, 0);
        run_frame(4, 0, 0, 2, 10, -10, 0, 0, 0);
        run_frame(6, 2, 0, 0, 0, 2, 0, 0, 0);
        run_frame(0, 0, 0, 0, 0, -10, 0, 0, 0);
        run_frame(1, 2, 2, 0, 0, -10, 0, 0, 0);

        // Reset mid-frame while words are outstanding and the sink is stalled.
        load_frame(8, -10, 0, extra);
        ready_mode = 3;
        wr_mode    = 0;
        tick(1, LW'(8));
        for (int n = 0; n < 50 && tb_issued < 3; n++) tick(0, '0);
        @(negedge clk);
        rstn_i    = 1'b0;
        start_i   = 1'b0;
        m_ready_i = 1'b0;
        #1;
        chk("midrst_valid", m_valid_o, 0);
        chk("midrst_rd_en", fifo_rd_en_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_first_last", {m_first_o, m_last_o}, 0);
        chk("midrst_data", m_data_o, 0);
        chk("midrst_err", err_nan_o, 0);
        exp_q.delete();
        exp_nan = 0;
        @(negedge clk);
        rstn_i = 1'b1;
        run_frame(5, 0, 0, 0, 0, -10, 0, 0, 0);

        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(1, 20), $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 8), $urandom_range(0, 6), -10, 0,
                      1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_stream_reader.md
# fp_stream_reader

Downstream drain stage for the BRAM-backed sync FIFO feeding the nonlinear approximation datapath. Issues FIFO read strobes under credit control, absorbs the FIFO's fixed read latency in a small skid buffer, and presents a valid/ready stream of FP32 operands framed by first/last flags. Frames are armed by the upstream start-marker pulse and terminated by a programmed element count.

## Interface
- DATA_WIDTH, 32, operand width (IEEE-754 single)
- RD_LATENCY, 2, cycles from fifo_rd_en_o high to valid fifo_data_i
- SKID_DEPTH, 4, skid buffer entries; must be ≥ RD_LATENCY+1, power of two
- LEN_WIDTH, 16, width of frame length and counters

- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- fifo_empty_i  in  1  FIFO empty flag
- fifo_wr_i  in  1  FIFO write enable (a write in the same cycle suppresses a FIFO pop)
- fifo_data_i  in  DATA_WIDTH  FIFO read data
- fifo_rd_en_o  out  1  FIFO read strobe
- start_i  in  1  frame-start pulse (marker detected at FIFO input)
- len_i  in  LEN_WIDTH  elements per frame, sampled on start_i; 0 treated as 1
- m_valid_o  out  1  output beat valid
- m_ready_i  in  1  downstream accept
- m_data_o  out  DATA_WIDTH  output operand
- m_first_o  out  1  beat is first of frame
- m_last_o  out  1  beat is last of frame
- done_o  out  1  one-cycle pulse after last beat accepted
- busy_o  out  1  FSM not IDLE
- err_nan_o  out  1  sticky NaN-seen flag

## Operation
- FSM: IDLE → RUN on start_i (latch len_i into len_q, clear issue/accept counters). RUN → DRAIN when issued count reaches len_q. DRAIN → IDLE when accepted count reaches len_q; done_o pulses that cycle+1. start_i outside IDLE is ignored.
- Issue rule (RUN only): fifo_rd_en_o = ~fifo_empty_i & ~fifo_wr_i & (inflight + skid_count < SKID_DEPTH) & (issued < len_q). Issue is counted only when fifo_rd_en_o is high.
- In-flight tracking: RD_LATENCY-deep shift register of issue bits; bit exiting pushes fifo_data_i into skid buffer. Overflow impossible by credit rule; assertion required.
- Output: m_valid_o = skid not empty; beat transfers when m_valid_o & m_ready_i. m_first_o on accepted-count 0, m_last_o on accepted-count len_q−1. m_data_o stable while m_valid_o & ~m_ready_i.
- Counters saturate never; widths LEN_WIDTH, compare with unsigned equality.
- Reset: all outputs 0, FSM IDLE, skid empty, in-flight shift register cleared, err_nan_o 0. Reset mid-frame discards in-flight and buffered data.

## Timing
- Earliest m_valid_o: RD_LATENCY+1 cycles after first fifo_rd_en_o (skid push registered).
- Sustained throughput 1 beat/cycle with m_ready_i high and FIFO non-empty, no writes.
- Simultaneous skid push and pop in same cycle: occupancy unchanged, both proceed.
- m_ready_i low: issue stops once credits exhausted; no beat lost, no duplicate.
- fifo_wr_i high: rd_en held low that cycle (FIFO gives write priority).
- len_q=1: first and last asserted on same beat.

## Configuration
- FP_READER_NAN_FILTER_EN defined: a word with exponent 8'hFF and mantissa ≠ 0 is replaced by 32'h0000_0000 on skid push and sets err_nan_o (sticky until reset). Infinities pass unchanged.
- Undefined: data passes unmodified; err_nan_o tied 0.

## Structure
- Shared package nla_stream_pkg: fsm state enum (IDLE, RUN, DRAIN), FP32 exponent/mantissa field constants, NaN detect function.
- One sub-module: stream_skid_fifo (register-based, SKID_DEPTH entries, push/pop/count).

## Test plan
- len_i=8, FIFO holds 8 words 1.0..8.0, m_ready_i=1 → 8 beats in order, first on 1.0, last on 8.0, done_o one cycle after, busy_o low.
- len_i=16, m_ready_i toggling 1/0 every cycle → all 16 values delivered once, fifo_rd_en_o never exceeds SKID_DEPTH outstanding.
- fifo_wr_i asserted every other cycle during RUN → rd_en never coincides with fifo_wr_i, data order intact.
- FIFO empty mid-frame for 10 cycles, len_i=4 → rd_en stalls, frame resumes, exactly 4 beats.
- Word 32'h7FC0_0000 in frame: macro defined → beat 0.0, err_nan_o=1; undefined → 32'h7FC0_0000, err_nan_o=0.
- rstn_i low for 1 cycle mid-frame with 3 words in flight → all outputs 0, FSM IDLE, next start_i frame clean.
